// File: rtl/ingress_frame_reader.sv
// Read side of the ingress packet buffer: pops a frame length, then streams ceil(len/16) words out.
// Optional frame/byte statistics counters are built when INGRESS_READER_STATS_EN is defined.
module ingress_frame_reader #(
  parameter int MAX_FRAME_SIZE  = 1522,
  parameter int HDR_RD_LATENCY  = 2,
  parameter int DATA_RD_LATENCY = 1
) (
  input  logic          clk_mem,
  input  logic          rd_reset,
  output logic          hdr_rd_en,
  input  logic [10:0]   hdr_rd_data,
  input  logic          hdr_rd_empty,
  output logic          data_rd_en,
  input  logic [127:0]  data_rd_data,
  input  logic [9:0]    data_rd_size,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_start,
  output logic          out_last,
  output logic [4:0]    out_bytes_valid,
  output logic [127:0]  out_data,
  output logic [10:0]   out_frame_len,
  output logic [15:0]   frames_dropped,
  output logic [31:0]   stat_frames,
  output logic [31:0]   stat_bytes
);

  localparam int DATA_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_WAIT,
    ST_DATA_WAIT,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 hdr_cnt_q, hdr_cnt_d;
  logic [10:0]                len_q, len_d;
  logic [7:0]                 words_q, words_d;
  logic [7:0]                 issue_q, issue_d;
  logic [7:0]                 beat_q, beat_d;
  logic [15:0]                dropped_q, dropped_d;
  logic [1:0]                 occ_q, occ_d;
  logic [DATA_RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]          buf0_q, buf0_d;
  logic [DATA_W-1:0]          buf1_q, buf1_d;

  logic       stream_rd;
  logic       pop;
  logic       arrive;
  logic       is_last;
  logic [3:0] inflight;
  logic [4:0] last_bytes;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // Word count is 8 bits so that lengths up to 2047 (128 words) still drain completely.
  function automatic logic [7:0] words_of(input logic [10:0] len);
    logic [11:0] sum;
    sum = {1'b0, len} + 12'd15;
    return sum[11:4];
  endfunction

  // Keep the leading n bytes (byte 0 in the top lane); n == 16 keeps the whole word.
  function automatic logic [DATA_W-1:0] keep_bytes(input logic [DATA_W-1:0] w, input logic [4:0] n);
    logic [DATA_W-1:0] tail;
    tail = {DATA_W{1'b1}} >> {n, 3'b000};
    return w & ~tail;
  endfunction

  assign out_valid  = (occ_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign arrive     = rd_pipe_q[DATA_RD_LATENCY-1];
  assign is_last    = (beat_q == words_q - 8'd1);
  assign last_bytes = (len_q[3:0] == 4'd0) ? 5'd16 : {1'b0, len_q[3:0]};

  assign out_start       = out_valid && (beat_q == 8'd0);
  assign out_last        = out_valid && is_last;
  assign out_bytes_valid = !out_valid ? 5'd0 : (is_last ? last_bytes : 5'd16);
  assign out_data        = !out_valid ? '0 : (is_last ? keep_bytes(buf0_q, last_bytes) : buf0_q);
  assign out_frame_len   = len_q;
  assign frames_dropped  = dropped_q;

  always_comb begin
    inflight = 4'd0;
    for (int i = 0; i < DATA_RD_LATENCY; i++) begin
      inflight = inflight + {3'b000, rd_pipe_q[i]};
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    len_d     = len_q;
    words_d   = words_q;
    issue_d   = issue_q;
    beat_d    = beat_q;
    dropped_d = dropped_q;
    hdr_rd_en  = 1'b0;
    data_rd_en = 1'b0;
    stream_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hdr_rd_empty) begin
          hdr_rd_en = 1'b1;
          hdr_cnt_d = 4'd1;
          state_d   = ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: begin
        if (hdr_cnt_q == 4'(HDR_RD_LATENCY)) begin
          len_d   = hdr_rd_data;
          words_d = words_of(hdr_rd_data);
          state_d = ST_DATA_WAIT;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 4'd1;
        end
      end
      ST_DATA_WAIT: begin
        // The header may cross ahead of the data commit; hold until the whole frame is present.
        if ({2'b00, words_q} <= data_rd_size) begin
          beat_d  = 8'd0;
          issue_d = words_q;
          if (len_q == 11'd0) begin
            dropped_d = sat_inc16(dropped_q);
            state_d   = ST_IDLE;
          end else if (len_q > 11'(MAX_FRAME_SIZE)) begin
            dropped_d = sat_inc16(dropped_q);
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        // Credit counts the beat leaving this cycle so the pipe sustains one word per cycle.
        if ((issue_q != 8'd0) && (data_rd_size != 10'd0) &&
            (({2'b00, occ_q} + inflight) < (4'd2 + {3'b000, pop}))) begin
          data_rd_en = 1'b1;
          stream_rd  = 1'b1;
          issue_d    = issue_q - 8'd1;
        end
        if (pop) begin
          beat_d = beat_q + 8'd1;
          if (is_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (issue_q == 8'd0) begin
          state_d = ST_IDLE;
        end else if (data_rd_size != 10'd0) begin
          data_rd_en = 1'b1;
          issue_d    = issue_q - 8'd1;
          if (issue_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rd_reset) begin
      hdr_rd_en  = 1'b0;
      data_rd_en = 1'b0;
      stream_rd  = 1'b0;
    end
  end

  always_comb begin
    rd_pipe_d[0] = stream_rd;
    for (int i = 1; i < DATA_RD_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (arrive) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
        buf0_d = data_rd_data;
      end else begin
        buf1_d = data_rd_data;
      end
    end
    occ_d = occ_q + {1'b0, arrive} - {1'b0, pop};
  end

  // ---- control registers ----
  always_ff @(posedge clk_mem) begin
    if (rd_reset) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= 4'd0;
      len_q     <= 11'd0;
      words_q   <= 8'd0;
      issue_q   <= 8'd0;
      beat_q    <= 8'd0;
      dropped_q <= 16'd0;
      occ_q     <= 2'd0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      len_q     <= len_d;
      words_q   <= words_d;
      issue_q   <= issue_d;
      beat_q    <= beat_d;
      dropped_q <= dropped_d;
      occ_q     <= occ_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  // ---- skid buffer payload ----
  always_ff @(posedge clk_mem) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

`ifdef INGRESS_READER_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_bytes_q, stat_bytes_d;

  always_comb begin
    stat_frames_d = stat_frames_q;
    stat_bytes_d  = stat_bytes_q;
    if (pop && is_last) begin
      stat_frames_d = stat_frames_q + 32'd1;
      stat_bytes_d  = stat_bytes_q + {21'd0, len_q};
    end
  end

  always_ff @(posedge clk_mem) begin
    if (rd_reset) begin
      stat_frames_q <= 32'd0;
      stat_bytes_q  <= 32'd0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_bytes_q  <= stat_bytes_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_bytes  = stat_bytes_q;
`else
  assign stat_frames = 32'd0;
  assign stat_bytes  = 32'd0;
`endif

endmodule
